// File: rtl/pattern_match_if.sv
// Control/data bundle for pattern_match_fsm: the master drives config and the
// serial stream, the slave returns status, the match pulse and the count.
interface pattern_match_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             start;
  logic             stop;
  logic             clear;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             in_valid;
  logic             in_bit;
  logic             busy;
  logic             cfg_err;
  logic             match;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output start, stop, clear, pat, pat_len, overlap, in_valid, in_bit,
    input  busy, cfg_err, match, match_cnt
  );

  modport slave (
    input  start, stop, clear, pat, pat_len, overlap, in_valid, in_bit,
    output busy, cfg_err, match, match_cnt
  );
endinterface

// File: rtl/pattern_match_fsm.sv
// Runtime-programmable serial pattern detector with IDLE/RUN control FSM.
// Optional feature macro PATMATCH_CNT_EN: saturating match counter and clear.
module pattern_match_fsm #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pattern_match_if.slave    bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_l;
  logic [LEN_W-1:0] len_l;
  logic             ovl_l;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic             cfg_err_q;
  logic             match_p1;

  logic             legal;
  logic             accept_p0;
  logic [PAT_W-1:0] hist_nxt;
  logic [LEN_W-1:0] fill_inc;
  logic             hit_p0;

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W; i++)
      if (i < int'(len)) m[i] = 1'b1;
    return m;
  endfunction

  assign legal     = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(PAT_W));
  assign accept_p0 = (state_q == RUN) && bus.in_valid && !bus.stop && !bus.start;
  assign hist_nxt  = {hist[PAT_W-2:0], bus.in_bit};
  assign fill_inc  = (fill < len_l) ? fill + LEN_W'(1) : fill;
  assign hit_p0    = accept_p0 && (fill_inc >= len_l) &&
                     (((hist_nxt ^ pat_l) & len_mask(len_l)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A start with an illegal length leaves the detector idle, even from RUN.
  always_comb begin
    state_d = state_q;
    if (bus.stop)       state_d = IDLE;
    else if (bus.start) state_d = legal ? RUN : IDLE;
  end

  always_comb begin
    bus.busy    = (state_q == RUN);
    bus.cfg_err = cfg_err_q;
    bus.match   = match_p1;
  end

  // Stage p0 -> p1: history/fill update and registered match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_l     <= '0;
      len_l     <= '0;
      ovl_l     <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      cfg_err_q <= 1'b0;
      match_p1  <= 1'b0;
    end else begin
      match_p1 <= hit_p0;
      if (bus.stop) begin
        hist <= '0;
        fill <= '0;
      end else if (bus.start) begin
        hist <= '0;
        fill <= '0;
        if (legal) begin
          pat_l     <= bus.pat;
          len_l     <= bus.pat_len;
          ovl_l     <= bus.overlap;
          cfg_err_q <= 1'b0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end else if (accept_p0) begin
        hist <= hist_nxt;
        fill <= (hit_p0 && !ovl_l) ? '0 : fill_inc;
      end
    end
  end

`ifdef PATMATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Clear beats a coincident match; a legal start restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt_q <= '0;
    else if (!bus.stop && bus.start && legal)  cnt_q <= '0;
    else if (bus.clear)                        cnt_q <= '0;
    else if (hit_p0)                           cnt_q <= sat_inc(cnt_q);
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_match_fsm.sv
// Directed bench for pattern_match_fsm: expected match pulses are queued as each
// bit is driven and popped when the output is sampled one edge later.
module tb_pattern_match_fsm;
  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_match_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  pattern_match_fsm #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit exp_q[$];

  function automatic int expc(input int n);
`ifdef PATMATCH_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_match(input string tag);
    bit e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=queue_empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {31'd0, bus.match}, {31'd0, e});
    end
  endtask

  task automatic send(input logic b, input bit exp, input string tag);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    exp_q.push_back(exp);
    tick();
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    pop_match(tag);
  endtask

  task automatic gap(input string tag);
    exp_q.push_back(1'b0);
    tick();
    pop_match(tag);
  endtask

  task automatic do_start(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    bus.pat     = p;
    bus.pat_len = l;
    bus.overlap = o;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    bus.pat = '0; bus.pat_len = '0; bus.overlap = 1'b0;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0;

    tick(); tick();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
    check("rst_match", {31'd0, bus.match}, 32'd0);
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1011 overlapping: hits on bits 4 and 7
    do_start(8'b1011, 4'd4, 1'b1);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    send(1, 0, "t1_b1"); send(0, 0, "t1_b2"); send(1, 0, "t1_b3"); send(1, 1, "t1_b4");
    send(0, 0, "t1_b5"); send(1, 0, "t1_b6"); send(1, 1, "t1_b7");
    check("t1_cnt", 32'(bus.match_cnt), 32'(expc(2)));

    // same stream non-overlapping: hit on bit 4 only
    do_start(8'b1011, 4'd4, 1'b0);
    check("t2_cnt_restart", 32'(bus.match_cnt), 32'd0);
    send(1, 0, "t2_b1"); send(0, 0, "t2_b2"); send(1, 0, "t2_b3"); send(1, 1, "t2_b4");
    send(0, 0, "t2_b5"); send(1, 0, "t2_b6"); send(1, 0, "t2_b7");
    check("t2_cnt", 32'(bus.match_cnt), 32'(expc(1)));

    // 11 overlapping with gaps: 3 hits
    do_start(8'b11, 4'd2, 1'b1);
    send(1, 0, "t3a_b1"); send(1, 1, "t3a_b2"); gap("t3a_g1");
    send(1, 1, "t3a_b3"); gap("t3a_g2"); send(1, 1, "t3a_b4");
    check("t3a_cnt", 32'(bus.match_cnt), 32'(expc(3)));

    // 11 non-overlapping with gaps: 2 hits
    do_start(8'b11, 4'd2, 1'b0);
    send(1, 0, "t3b_b1"); send(1, 1, "t3b_b2"); gap("t3b_g1");
    send(1, 0, "t3b_b3"); gap("t3b_g2"); send(1, 1, "t3b_b4");
    check("t3b_cnt", 32'(bus.match_cnt), 32'(expc(2)));

    // stop with a valid bit the same cycle: bit discarded, count held
    bus.stop = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    exp_q.push_back(1'b0);
    tick();
    bus.stop = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    pop_match("stop_bit");
    check("stop_busy", {31'd0, bus.busy}, 32'd0);
    check("stop_cnt_held", 32'(bus.match_cnt), 32'(expc(2)));
    send(1, 0, "idle_bit1"); send(1, 0, "idle_bit2");

    // pat_len=1, CNT_W=2: saturate at 3, then clear with coincident match
    do_start(8'b1, 4'd1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      send(1, 1, "t4_hit");
      check("t4_cnt", 32'(bus.match_cnt), 32'(expc(i > 3 ? 3 : i)));
    end
    bus.clear = 1'b1;
    send(1, 1, "t4_clear_hit");
    bus.clear = 1'b0;
    check("t4_cnt_cleared", 32'(bus.match_cnt), 32'd0);
    send(1, 1, "t4_post_clear");
    check("t4_cnt_post", 32'(bus.match_cnt), 32'(expc(1)));

    // illegal starts set cfg_err and leave the counter alone
    do_start(8'b1, 4'd0, 1'b0);
    check("t5_err0", {31'd0, bus.cfg_err}, 32'd1);
    check("t5_busy0", {31'd0, bus.busy}, 32'd0);
    check("t5_cnt_kept", 32'(bus.match_cnt), 32'(expc(1)));
    do_start(8'b1, 4'd9, 1'b0);
    check("t5_err9", {31'd0, bus.cfg_err}, 32'd1);
    check("t5_busy9", {31'd0, bus.busy}, 32'd0);
    do_start(8'b1011, 4'd4, 1'b1);
    check("t5_err_clr", {31'd0, bus.cfg_err}, 32'd0);
    check("t5_busy_legal", {31'd0, bus.busy}, 32'd1);

    // async reset after 3 of 4 matching bits wipes history
    send(1, 0, "t6_b1"); send(0, 0, "t6_b2"); send(1, 0, "t6_b3");
    bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_rst_match", {31'd0, bus.match}, 32'd0);
    tick();
    check("t6_rst_match_edge", {31'd0, bus.match}, 32'd0);
    check("t6_rst_cnt", 32'(bus.match_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    do_start(8'b1011, 4'd4, 1'b1);
    send(1, 0, "t6_f1"); send(0, 0, "t6_f2"); send(1, 0, "t6_f3"); send(1, 1, "t6_f4");
    check("t6_cnt", 32'(bus.match_cnt), 32'(expc(1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
